// File: rtl/ranc_loader_pkg.sv
// Shared definitions for the RANC core configuration loader:
// opcodes, header field positions, FSM states and the core-select decoder.
package ranc_loader_pkg;

  localparam logic [3:0] OP_PARAM = 4'd1;
  localparam logic [3:0] OP_INST  = 4'd2;

  localparam int HDR_OP_MSB   = 31;
  localparam int HDR_OP_LSB   = 28;
  localparam int HDR_CORE_MSB = 27;
  localparam int HDR_CORE_LSB = 24;
  localparam int HDR_CNT_MSB  = 15;
  localparam int HDR_CNT_LSB  = 0;

  localparam int SLOTS_PER_WORD = 16;

  typedef enum logic [2:0] {
    IDLE,
    PARAM,
    INST_FETCH,
    INST_UNPACK,
    DONE,
    ERR
  } state_t;

  // Full 16-way decode of the header core field; callers keep the low NUM_CORES bits.
  function automatic logic [15:0] core_onehot(input logic [3:0] core);
    return 16'd1 << core;
  endfunction

endpackage

// File: rtl/loader_inst_unpacker.sv
// Splits one latched 32-bit instruction word into sixteen 2-bit instructions,
// one per cycle, producing the shared address/data buses.
module loader_inst_unpacker
  import ranc_loader_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [31:0]      i_word,
  input  logic [IDX_W-1:0] i_word_idx,
  output logic [IDX_W+3:0] o_addr,
  output logic [1:0]       o_data,
  output logic             o_last_slot
);

  logic [31:0]      r_word;
  logic [3:0]       r_k;
  logic             r_valid;
  logic [IDX_W+3:0] r_addr;
  logic [1:0]       r_data;

  logic [1:0]       w_slot [SLOTS_PER_WORD];
  logic [3:0]       w_k_next;

  genvar gi;
  generate
    for (gi = 0; gi < SLOTS_PER_WORD; gi++) begin : g_slot
      assign w_slot[gi] = r_word[2*gi+1:2*gi];
    end
  endgenerate

  assign w_k_next = r_k + 4'd1;

  // Address and data are registered so they line up with the registered write strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word  <= '0;
      r_k     <= '0;
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (i_load) begin
      r_word  <= i_word;
      r_k     <= '0;
      r_valid <= 1'b1;
      r_addr  <= {i_word_idx, 4'd0};
      r_data  <= i_word[1:0];
    end else if (r_valid) begin
      if (r_k == 4'd15) begin
        r_valid <= 1'b0;
      end else begin
        r_k    <= w_k_next;
        r_addr <= {r_addr[IDX_W+3:4], w_k_next};
        r_data <= w_slot[w_k_next];
      end
    end
  end

  assign o_addr      = r_addr;
  assign o_data      = r_data;
  assign o_last_slot = r_valid && (r_k == 4'd15);

endmodule

// File: rtl/core_config_loader.sv
// Configuration sequencer for a RANC core grid: decodes header/data words and
// drives one-hot parameter and neuron-instruction write strobes to each core.
module core_config_loader
  import ranc_loader_pkg::*;
#(
  parameter int NUM_CORES   = 6,
  parameter int NUM_NEURONS = 256
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [31:0]                    s_data,
  input  logic                           s_valid,
  output logic                           s_ready,
  output logic [NUM_CORES-1:0]           param_wen,
  output logic [31:0]                    param_data_out,
  output logic [NUM_CORES-1:0]           neuron_inst_wen,
  output logic [$clog2(NUM_NEURONS)-1:0] neuron_inst_address,
  output logic [1:0]                     neuron_inst_data,
  output logic                           busy,
  output logic                           done,
  output logic                           error
);

  localparam int ADDR_W    = $clog2(NUM_NEURONS);
  localparam int IDX_W     = ADDR_W - 4;
  localparam int NUM_WORDS = NUM_NEURONS / SLOTS_PER_WORD;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  state_t               r_state;
  logic                 r_s_ready;
  logic [NUM_CORES-1:0] r_onehot;
  logic [15:0]          r_count;
  logic [IDX_W-1:0]     r_word_idx;
  logic [NUM_CORES-1:0] r_param_wen;
  logic [31:0]          r_param_data;
  logic [NUM_CORES-1:0] r_inst_wen;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_error;

  logic                 w_xfer;
  logic [3:0]           w_op;
  logic [3:0]           w_core;
  logic [15:0]          w_count;
  logic [15:0]          w_dec;
  logic [NUM_CORES-1:0] w_onehot;
  logic                 w_bad_hdr;
  logic                 w_load;
  logic                 w_last_slot;

  assign w_xfer    = s_valid && r_s_ready;
  assign w_op      = s_data[HDR_OP_MSB:HDR_OP_LSB];
  assign w_core    = s_data[HDR_CORE_MSB:HDR_CORE_LSB];
  assign w_count   = s_data[HDR_CNT_MSB:HDR_CNT_LSB];
  assign w_dec     = core_onehot(w_core);
  assign w_onehot  = w_dec[NUM_CORES-1:0];
  assign w_bad_hdr = !((w_op == OP_PARAM) || (w_op == OP_INST)) || (32'(w_core) >= NUM_CORES);
  assign w_load    = w_xfer && (r_state == INST_FETCH);

  loader_inst_unpacker #(
    .IDX_W (IDX_W)
  ) u_unpacker (
    .clk         (clk),
    .rst_n       (reset_n),
    .i_load      (w_load),
    .i_word      (s_data),
    .i_word_idx  (r_word_idx),
    .o_addr      (neuron_inst_address),
    .o_data      (neuron_inst_data),
    .o_last_slot (w_last_slot)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_s_ready    <= 1'b0;
      r_onehot     <= '0;
      r_count      <= '0;
      r_word_idx   <= '0;
      r_param_wen  <= '0;
      r_param_data <= '0;
      r_inst_wen   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_param_wen <= '0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      case (r_state)
        IDLE: begin
          // Also raises s_ready one cycle after reset release.
          r_s_ready <= 1'b1;
          if (w_xfer) begin
            r_busy   <= 1'b1;
            r_onehot <= w_onehot;
            if (w_bad_hdr) begin
              r_state   <= ERR;
              r_error   <= 1'b1;
              r_s_ready <= 1'b0;
            end else if (w_op == OP_PARAM && w_count == 16'd0) begin
              r_state   <= DONE;
              r_done    <= 1'b1;
              r_s_ready <= 1'b0;
            end else if (w_op == OP_PARAM) begin
              r_state <= PARAM;
              r_count <= w_count;
            end else begin
              r_state    <= INST_FETCH;
              r_word_idx <= '0;
            end
          end
        end
        PARAM: begin
          if (w_xfer) begin
            r_param_wen  <= r_onehot;
            r_param_data <= s_data;
            r_count      <= r_count - 16'd1;
            if (r_count == 16'd1) begin
              r_state   <= DONE;
              r_done    <= 1'b1;
              r_s_ready <= 1'b0;
            end
          end
        end
        INST_FETCH: begin
          if (w_xfer) begin
            r_state    <= INST_UNPACK;
            r_inst_wen <= r_onehot;
            r_s_ready  <= 1'b0;
          end
        end
        INST_UNPACK: begin
          if (w_last_slot) begin
            r_inst_wen <= '0;
            if (r_word_idx == LAST_IDX) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_word_idx <= r_word_idx + 1'b1;
              r_state    <= INST_FETCH;
              r_s_ready  <= 1'b1;
            end
          end
        end
        DONE, ERR: begin
          r_state   <= IDLE;
          r_busy    <= 1'b0;
          r_s_ready <= 1'b1;
        end
        default: begin
          r_state   <= IDLE;
          r_busy    <= 1'b0;
          r_s_ready <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready         = r_s_ready;
  assign param_wen       = r_param_wen;
  assign param_data_out  = r_param_data;
  assign neuron_inst_wen = r_inst_wen;
  assign busy            = r_busy;
  assign done            = r_done;
  assign error           = r_error;

endmodule

// File: tb/tb_core_config_loader.sv
// Scoreboard bench for core_config_loader: the driver pushes expected strobes and
// done/error events with their cycle numbers; a negedge monitor pops and compares.
module tb_core_config_loader;

  localparam int NC = 6;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [NC-1:0] param_wen;
  logic [31:0] param_data_out;
  logic [NC-1:0] neuron_inst_wen;
  logic [7:0]  neuron_inst_address;
  logic [1:0]  neuron_inst_data;
  logic        busy;
  logic        done;
  logic        error;

  core_config_loader #(
    .NUM_CORES   (NC),
    .NUM_NEURONS (256)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .s_data              (s_data),
    .s_valid             (s_valid),
    .s_ready             (s_ready),
    .param_wen           (param_wen),
    .param_data_out      (param_data_out),
    .neuron_inst_wen     (neuron_inst_wen),
    .neuron_inst_address (neuron_inst_address),
    .neuron_inst_data    (neuron_inst_data),
    .busy                (busy),
    .done                (done),
    .error               (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_inst;
    int core;
    int val;
    int dat;
    int cyc;
  } exp_t;

  typedef struct {
    bit is_err;
    int cyc;
  } ev_t;

  exp_t sq[$];
  ev_t  eq[$];
  exp_t mon_e;
  ev_t  mon_ev;
  int   total = 0;
  int   bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: every strobe and every done/error pulse must match the head of its queue.
  always @(negedge clk) begin
    if (reset_n) begin
      if (param_wen != '0 || neuron_inst_wen != '0) begin
        check("single_wen", 64'($countones({param_wen, neuron_inst_wen})), 64'd1);
        if (sq.size() == 0) begin
          fail("unexpected_strobe");
        end else begin
          mon_e = sq.pop_front();
          if (mon_e.is_inst) begin
            check("inst_wen", 64'(neuron_inst_wen), 64'(1) << mon_e.core);
            check("inst_addr", 64'(neuron_inst_address), 64'(mon_e.val));
            check("inst_data", 64'(neuron_inst_data), 64'(mon_e.dat));
            check("inst_cycle", 64'(cyc), 64'(mon_e.cyc));
            check("ready_in_unpack", 64'(s_ready), 64'd0);
          end else begin
            check("param_wen", 64'(param_wen), 64'(1) << mon_e.core);
            check("param_data", 64'(param_data_out), 64'(unsigned'(mon_e.val)));
            check("param_cycle", 64'(cyc), 64'(mon_e.cyc));
          end
          $display("strobe %s core=%0d val=%0h cycle=%0d", mon_e.is_inst ? "inst" : "param",
                   mon_e.core, mon_e.val, cyc);
        end
      end
      if (done || error) begin
        if (eq.size() == 0) begin
          fail(done ? "unexpected_done" : "unexpected_error");
        end else begin
          mon_ev = eq.pop_front();
          check("event_is_error", 64'(error), 64'(mon_ev.is_err));
          check("event_is_done", 64'(done), 64'(!mon_ev.is_err));
          check("event_cycle", 64'(cyc), 64'(mon_ev.cyc));
          $display("event %s cycle=%0d", error ? "error" : "done", cyc);
        end
      end
    end
  end

  // kind: 0 header only, 1 param word, 2 inst word, 3 header -> done, 4 header -> error.
  task automatic send(input logic [31:0] w, input int kind, input int core, input int idx, input bit last);
    int n = 0;
    int c;
    s_data = w;
    s_valid = 1'b1;
    while (!s_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      fail("send_timeout");
      s_valid = 1'b0;
      return;
    end
    c = cyc;
    case (kind)
      1: begin
        sq.push_back('{1'b0, core, int'(w), 0, c + 1});
        if (last) eq.push_back('{1'b0, c + 1});
      end
      2: begin
        for (int k = 0; k < 16; k++)
          sq.push_back('{1'b1, core, idx * 16 + k, int'((w >> (2 * k)) & 32'd3), c + 1 + k});
        if (last) eq.push_back('{1'b0, c + 17});
      end
      3: eq.push_back('{1'b0, c + 1});
      4: eq.push_back('{1'b1, c + 1});
      default: ;
    endcase
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (eq.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) fail("idle_timeout");
    @(negedge clk);
    @(negedge clk);
    check("busy_idle", 64'(busy), 64'd0);
    check("ready_idle", 64'(s_ready), 64'd1);
    check("strobes_all_seen", 64'(sq.size()), 64'd0);
  endtask

  // fixed_gap >= 0: that many idle cycles after the first data word only; else random gaps.
  task automatic cmd(input int op, input int core, input int count, input int fixed_gap,
                     input bit use_w0, input logic [31:0] w0);
    logic [31:0] hdr;
    logic [31:0] w;
    int gap;
    hdr = {4'(op), 4'(core), 8'($urandom), 16'(count)};
    $display("command op=%0d core=%0d count=%0d", op, core, count);
    if (!((op == 1 || op == 2) && core < NC)) begin
      send(hdr, 4, core, 0, 1'b0);
    end else if (op == 1 && count == 0) begin
      send(hdr, 3, core, 0, 1'b0);
    end else begin
      send(hdr, 0, core, 0, 1'b0);
      for (int i = 0; i < ((op == 1) ? count : 16); i++) begin
        w = (i == 0 && use_w0) ? w0 : $urandom;
        if (op == 1) send(w, 1, core, 0, i == count - 1);
        else send(w, 2, core, i, i == 15);
        gap = (fixed_gap >= 0) ? ((i == 0) ? fixed_gap : 0) : int'($urandom_range(0, 2));
        repeat (gap) @(negedge clk);
      end
    end
    wait_idle();
  endtask

  initial begin
    int n;
    int r;
    int op;
    repeat (3) @(negedge clk);
    check("rst_param_wen", 64'(param_wen), 64'd0);
    check("rst_inst_wen", 64'(neuron_inst_wen), 64'd0);
    check("rst_param_data", 64'(param_data_out), 64'd0);
    check("rst_inst_addr", 64'(neuron_inst_address), 64'd0);
    check("rst_inst_data", 64'(neuron_inst_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_ready", 64'(s_ready), 64'd0);
    reset_n = 1'b1;
    #1;
    check("ready_first_cycle", 64'(s_ready), 64'd0);
    @(negedge clk);
    check("ready_second_cycle", 64'(s_ready), 64'd1);
    check("busy_after_reset", 64'(busy), 64'd0);

    cmd(1, 2, 3, 2, 1'b0, 32'd0);
    cmd(2, 5, 0, 0, 1'b1, 32'hE4E4_E4E4);
    cmd(15, int'($urandom_range(0, 15)), int'($urandom_range(0, 9)), -1, 1'b0, 32'd0);
    cmd(1, 7, 5, -1, 1'b0, 32'd0);
    cmd(1, 0, 0, -1, 1'b0, 32'd0);

    // Reset in the middle of an instruction load, at address 37.
    $display("command inst core=5 with reset at address 37");
    send({4'd2, 4'd5, 24'd0}, 0, 5, 0, 1'b0);
    for (int i = 0; i < 3; i++) send($urandom, 2, 5, i, 1'b0);
    n = 0;
    while (!(neuron_inst_wen != '0 && neuron_inst_address == 8'd37) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail("reach_addr37_timeout");
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_inst_wen", 64'(neuron_inst_wen), 64'd0);
    check("midrst_param_wen", 64'(param_wen), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_ready", 64'(s_ready), 64'd0);
    sq.delete();
    eq.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    cmd(1, 1, int'($urandom_range(1, 5)), -1, 1'b0, 32'd0);

    for (int t = 0; t < 8; t++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4) op = 1;
      else if (r < 7) op = 2;
      else op = (r == 7) ? 0 : int'($urandom_range(3, 15));
      cmd(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 6)), -1, 1'b0, 32'd0);
    end

    check("final_strobe_queue", 64'(sq.size()), 64'd0);
    check("final_event_queue", 64'(eq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
